bus_datapath_seq: RTL and testbench



---
 rtl/bus_datapath_seq.sv | 219 +++++++++++++++++++++
 tb/tb_bus_datapath_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
// Multi-cycle register-machine datapath: FETCH/DECODE/EXEC/MEM/WB sequencer
// with a general register file, Y/Z/MDR staging registers and a simple memory bus.
module bus_datapath_seq #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16,
   parameter int ADDR_W = 9
) (
   input  logic                     clock,
   input  logic                     clear,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     mem_rd,
   output logic                     mem_wr,
   input  logic                     mem_ack,
   input  logic [$clog2(NREGS)-1:0] dbg_sel,
   output logic [DATA_W-1:0]        dbg_data,
   output logic [ADDR_W-1:0]        pc_out,
   output logic                     halted,
   output logic                     illegal,
   output logic [2:0]               dbg_state
);

   localparam int RW = $clog2(NREGS);
   localparam int CW = DATA_W - 5 - 2 * RW;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   y_q, y_d;
   logic [DATA_W-1:0]   z_q, z_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;
   logic                halted_q, halted_d;
   logic                illegal_q, illegal_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   regs_d [NREGS];

   logic [4:0]          op;
   logic [RW-1:0]       ra, rb, rc;
   logic [DATA_W-1:0]   c_ext;
   logic [DATA_W-1:0]   ra_val, rb_val, rc_val;
   logic                base_zero;
   logic                br_take;

   // Instruction fields; C is sign-extended and rc is the top RW bits of C.
   assign op     = ir_q[DATA_W-1 -: 5];
   assign ra     = ir_q[DATA_W-6 -: RW];
   assign rb     = ir_q[DATA_W-6-RW -: RW];
   assign rc     = ir_q[CW-1 -: RW];
   assign c_ext  = {{(DATA_W-CW){ir_q[CW-1]}}, ir_q[CW-1:0]};
   assign ra_val = regs_q[ra];
   assign rb_val = regs_q[rb];
   assign rc_val = regs_q[rc];

   // Memory-addressing forms treat rb=0 as a literal zero base rather than R0.
   assign base_zero = ((op == OP_LD) || (op == OP_LDI) || (op == OP_ST)) && (rb == '0);

   always_comb begin
      br_take = 1'b0;
      case (rb[1:0])
         2'b00:   br_take = (ra_val == '0);
         2'b01:   br_take = (ra_val != '0);
         2'b10:   br_take = !ra_val[DATA_W-1] && (ra_val != '0);
         default: br_take = ra_val[DATA_W-1];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      y_d       = y_q;
      z_d       = z_q;
      mdr_d     = mdr_q;
      halted_d  = halted_q;
      illegal_d = 1'b0;
      regs_d    = regs_q;
      case (state_q)
         FETCH: begin
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + PC_ONE;
               state_d = DECODE;
            end
         end
         DECODE: begin
            y_d     = base_zero ? '0 : rb_val;
            state_d = EXEC;
         end
         EXEC: begin
            case (op)
               OP_LD, OP_ST: begin
                  z_d     = y_q + c_ext;
                  state_d = MEM;
               end
               OP_LDI, OP_ADDI: begin
                  z_d     = y_q + c_ext;
                  state_d = WB;
               end
               OP_ADD: begin
                  z_d     = y_q + rc_val;
                  state_d = WB;
               end
               OP_SUB: begin
                  z_d     = y_q - rc_val;
                  state_d = WB;
               end
               OP_AND: begin
                  z_d     = y_q & rc_val;
                  state_d = WB;
               end
               OP_OR: begin
                  z_d     = y_q | rc_val;
                  state_d = WB;
               end
               OP_BR: begin
                  if (br_take) pc_d = pc_q + c_ext[ADDR_W-1:0];
                  state_d = FETCH;
               end
               OP_NOP: begin
                  state_d = FETCH;
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  state_d  = HALT;
               end
               default: begin
                  illegal_d = 1'b1;
                  state_d   = FETCH;
               end
            endcase
         end
         MEM: begin
            if (mem_ack) begin
               if (op == OP_LD) begin
                  mdr_d   = mem_rdata;
                  state_d = WB;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         WB: begin
            regs_d[ra] = (op == OP_LD) ? mdr_q : z_q;
            state_d    = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         y_q       <= '0;
         z_q       <= '0;
         mdr_q     <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         y_q       <= y_d;
         z_q       <= z_d;
         mdr_q     <= mdr_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Bus handshake: mem_rd/mem_wr is a request held (with mem_addr/mem_wdata stable)
   // until the rising edge where mem_ack=1 completes it; mem_ack outside a request is
   // ignored. Strobes decode straight from state and drop as soon as clear is low.
   assign mem_rd    = clear && ((state_q == FETCH) || ((state_q == MEM) && (op == OP_LD)));
   assign mem_wr    = clear && (state_q == MEM) && (op == OP_ST);
   assign mem_addr  = (state_q == MEM) ? z_q[ADDR_W-1:0] : pc_q;
   assign mem_wdata = ra_val;

   assign dbg_data  = regs_q[dbg_sel];
   assign pc_out    = pc_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;
   assign dbg_state = state_q;

   a_strobe_mutex: assert property (@(posedge clock) disable iff (!clear) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Bench for bus_datapath_seq: wait-state memory model on a 32-bit instance with a
// transaction scoreboard, plus a 16-bit/8-register instance running a short program.
module tb_bus_datapath_seq;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] OP_BAD  = 5'b11111;

   // clock / reset
   logic clock;
   logic clear, clear_b;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // 32-bit instance
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_rd, mem_wr, mem_ack;
   logic [3:0]  dbg_sel;
   logic [31:0] dbg_data;
   logic [8:0]  pc_out;
   logic        halted, illegal;
   logic [2:0]  dbg_state;

   bus_datapath_seq u_dut (
      .clock(clock), .clear(clear),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data),
      .pc_out(pc_out), .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
   );

   // 16-bit, 8-register instance
   logic [8:0]  mem_addr_b;
   logic [15:0] mem_wdata_b, mem_rdata_b;
   logic        mem_rd_b, mem_wr_b, mem_ack_b;
   logic [2:0]  dbg_sel_b;
   logic [15:0] dbg_data_b;
   logic [8:0]  pc_out_b;
   logic        halted_b, illegal_b;
   logic [2:0]  dbg_state_b;
   logic [15:0] imgb [512];

   bus_datapath_seq #(.DATA_W(16), .NREGS(8), .ADDR_W(9)) u_dut_b (
      .clock(clock), .clear(clear_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
      .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_ack(mem_ack_b),
      .dbg_sel(dbg_sel_b), .dbg_data(dbg_data_b),
      .pc_out(pc_out_b), .halted(halted_b), .illegal(illegal_b), .dbg_state(dbg_state_b)
   );
   assign mem_ack_b   = 1'b1;
   assign mem_rdata_b = imgb[mem_addr_b];

   // memory model with programmable wait states
   logic [31:0] img [512];
   logic [31:0] mem [512];
   logic        load_req, force_ack;
   int          ack_wait, wait_cnt;

   assign mem_rdata = mem[mem_addr];
   always_comb mem_ack = force_ack || ((mem_rd || mem_wr) && (wait_cnt >= ack_wait));

   always @(posedge clock) begin
      if (load_req) mem <= img;
      else if (mem_wr && mem_ack) mem[mem_addr] <= mem_wdata;
      if ((mem_rd || mem_wr) && !mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   // scoreboard: entry = {is_write, addr, data}
   logic [41:0] exp_q [$];
   int n_chk, n_err;
   int cnt_ill, cnt_wr;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!clear) begin
         cnt_ill <= 0;
         cnt_wr  <= 0;
      end else begin
         if (illegal) cnt_ill <= cnt_ill + 1;
         if (mem_wr) cnt_wr <= cnt_wr + 1;
         if (mem_ack && (mem_rd || mem_wr)) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
            else check("sb_txn", {22'd0, mem_wr, mem_addr, mem_rd ? mem_rdata : mem_wdata},
                       {22'd0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   function automatic logic [31:0] enc(input logic [4:0] op, input int ra, input int rb, input int c);
      logic [31:0] w;
      w = {op, ra[3:0], rb[3:0], c[18:0]};
      return w;
   endfunction

   function automatic logic [15:0] encb(input logic [4:0] op, input int ra, input int rb, input int c);
      logic [15:0] w;
      w = {op, ra[2:0], rb[2:0], c[4:0]};
      return w;
   endfunction

   task automatic push_fetch(input int a);
      exp_q.push_back({1'b0, 9'(a), img[a]});
   endtask

   task automatic push_data(input logic wr, input int a, input logic [31:0] d);
      exp_q.push_back({wr, 9'(a), d});
   endtask

   task automatic reset_a(input int waits);
      clear     = 1'b0;
      force_ack = 1'b0;
      ack_wait  = waits;
      exp_q.delete();
      @(posedge clock); #1;
      for (int i = 0; i < 512; i++) img[i] = '0;
   endtask

   task automatic go_a();
      load_req = 1'b1;
      @(posedge clock); #1;
      load_req = 1'b0;
      clear    = 1'b1;
   endtask

   task automatic run_a(input int budget, output int cycles);
      cycles = 0;
      while (!halted && cycles < budget) begin
         @(posedge clock); #1;
         cycles++;
      end
      check("halted", 64'(halted), 64'd1);
   endtask

   task automatic chk_reg(input int r, input logic [31:0] exp);
      dbg_sel = 4'(r);
      #1;
      check($sformatf("r%0d", r), 64'(dbg_data), 64'(exp));
   endtask

   task automatic chk_sb_empty();
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   int cyc;
   int ca, cb, cc;
   logic [31:0] va, vb, vc;

   initial begin
      clear = 1'b0; clear_b = 1'b0; load_req = 1'b0; force_ack = 1'b0;
      ack_wait = 0; dbg_sel = '0; dbg_sel_b = '0;
      n_chk = 0; n_err = 0;
      for (int i = 0; i < 512; i++) imgb[i] = '0;
      repeat (2) @(posedge clock); #1;

      // reset state
      check("rst_pc", 64'(pc_out), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      check("rst_strobes", 64'({mem_rd, mem_wr}), 64'd0);
      chk_reg(0, 32'd0);

      // short program, zero wait states
      reset_a(0);
      img[0] = enc(OP_LDI, 2, 0, 5);
      img[1] = enc(OP_ADDI, 3, 2, -2);
      img[2] = enc(OP_ADD, 4, 2, 3 << 15);
      img[3] = enc(OP_HALT, 0, 0, 0);
      for (int i = 0; i < 4; i++) push_fetch(i);
      go_a();
      run_a(100, cyc);
      check("t1_cycles", 64'(cyc), 64'd15);
      check("t1_pc", 64'(pc_out), 64'd4);
      chk_reg(2, 32'd5);
      chk_reg(3, 32'd3);
      chk_reg(4, 32'd8);
      repeat (3) @(posedge clock); #1;
      check("halt_quiet", 64'({mem_rd, mem_wr}), 64'd0);
      check("halt_pc", 64'(pc_out), 64'd4);
      chk_sb_empty();

      // load then store, two wait cycles per request
      reset_a(2);
      img[0]  = enc(OP_LD, 1, 0, 20);
      img[1]  = enc(OP_ST, 1, 0, 21);
      img[2]  = enc(OP_HALT, 0, 0, 0);
      img[20] = 32'h0000ABCD;
      push_fetch(0); push_data(1'b0, 20, 32'h0000ABCD);
      push_fetch(1); push_data(1'b1, 21, 32'h0000ABCD);
      push_fetch(2);
      go_a();
      run_a(200, cyc);
      check("t2_cycles", 64'(cyc), 64'd22);
      check("t2_m21", 64'(mem[21]), 64'h0000ABCD);
      check("t2_wr_cycles", 64'(cnt_wr), 64'd3);
      chk_reg(1, 32'h0000ABCD);
      chk_sb_empty();

      // branches, illegal opcode, PC wrap
      reset_a(0);
      img[0]   = enc(OP_LDI, 5, 0, 0);
      img[1]   = enc(OP_BR, 0, 0, 8);
      img[10]  = enc(OP_BR, 5, 0, 3);
      img[14]  = enc(OP_LDI, 5, 0, 1);
      img[15]  = enc(OP_BR, 5, 1, -6);
      img[11]  = enc(OP_BAD, 5, 5, 7);
      img[12]  = enc(OP_ADDI, 9, 0, -1);
      img[13]  = enc(OP_BR, 9, 3, 497);
      img[511] = enc(OP_BR, 5, 2, 20);
      img[20]  = enc(OP_HALT, 0, 0, 0);
      push_fetch(0); push_fetch(1); push_fetch(10); push_fetch(14); push_fetch(15);
      push_fetch(10); push_fetch(11); push_fetch(12); push_fetch(13); push_fetch(511);
      push_fetch(20);
      go_a();
      run_a(300, cyc);
      check("t3_cycles", 64'(cyc), 64'd36);
      check("t3_pc", 64'(pc_out), 64'd21);
      check("t3_illegal_cycles", 64'(cnt_ill), 64'd1);
      chk_reg(0, 32'd0);
      chk_reg(5, 32'd1);
      chk_reg(9, 32'hFFFFFFFF);
      chk_sb_empty();

      // randomized ALU / base-register program
      for (int it = 0; it < 3; it++) begin
         reset_a($urandom_range(0, 2));
         ca = int'($urandom_range(1, 262143));
         cb = int'($urandom_range(0, 524287)) - 262144;
         cc = int'($urandom_range(0, 524287)) - 262144;
         va = 32'(ca); vb = 32'(cb); vc = 32'(cc);
         img[0]  = enc(OP_LDI, 0, 0, ca);
         img[1]  = enc(OP_LDI, 1, 0, cb);
         img[2]  = enc(OP_LDI, 6, 0, 1);
         img[3]  = enc(OP_SUB, 2, 0, 1 << 15);
         img[4]  = enc(OP_AND, 3, 0, 1 << 15);
         img[5]  = enc(OP_OR, 4, 0, 1 << 15);
         img[6]  = enc(OP_ADD, 7, 0, 1 << 15);
         img[7]  = enc(OP_ADDI, 8, 0, cc);
         img[8]  = enc(OP_LDI, 9, 6, 4);
         img[9]  = enc(OP_ST, 2, 6, 40);
         img[10] = enc(OP_LD, 10, 0, 41);
         img[11] = enc(OP_HALT, 0, 0, 0);
         for (int i = 0; i < 10; i++) push_fetch(i);
         push_data(1'b1, 41, va - vb);
         push_fetch(10);
         push_data(1'b0, 41, va - vb);
         push_fetch(11);
         go_a();
         run_a(500, cyc);
         chk_reg(0, va);
         chk_reg(1, vb);
         chk_reg(6, 32'd1);
         chk_reg(2, va - vb);
         chk_reg(3, va & vb);
         chk_reg(4, va | vb);
         chk_reg(7, va + vb);
         chk_reg(8, va + vc);
         chk_reg(9, 32'd5);
         chk_reg(10, va - vb);
         chk_sb_empty();
      end

      // reset while a fetch is stalled, late ack during reset
      reset_a(0);
      img[0] = enc(OP_LDI, 2, 0, 5);
      img[1] = enc(OP_HALT, 0, 0, 0);
      push_fetch(0);
      go_a();
      @(posedge clock); #1;
      ack_wait = 100;
      repeat (5) @(posedge clock);
      #1;
      check("t5_stall_rd", 64'(mem_rd), 64'd1);
      check("t5_stall_addr", 64'(mem_addr), 64'd1);
      chk_reg(2, 32'd5);
      clear = 1'b0;
      #1;
      check("t5_abort_rd", 64'(mem_rd), 64'd0);
      check("t5_abort_pc", 64'(pc_out), 64'd0);
      for (int r = 0; r < 16; r++) chk_reg(r, 32'd0);
      force_ack = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      force_ack = 1'b0;
      clear = 1'b1;
      #1;
      check("t5_restart_rd", 64'(mem_rd), 64'd1);
      check("t5_restart_addr", 64'(mem_addr), 64'd0);
      check("t5_restart_pc", 64'(pc_out), 64'd0);
      chk_sb_empty();
      clear = 1'b0;

      // 16-bit / 8-register instance
      imgb[0] = encb(OP_LDI, 2, 0, 5);
      imgb[1] = encb(OP_ADDI, 3, 2, 'h1E);
      imgb[2] = encb(OP_ADD, 4, 2, 3 << 2);
      imgb[3] = encb(OP_ADDI, 5, 2, 'h1F);
      imgb[4] = encb(OP_HALT, 0, 0, 0);
      @(posedge clock); #1;
      clear_b = 1'b1;
      cyc = 0;
      while (!halted_b && cyc < 100) begin
         @(posedge clock); #1;
         cyc++;
      end
      check("b_halted", 64'(halted_b), 64'd1);
      check("b_cycles", 64'(cyc), 64'd19);
      check("b_pc", 64'(pc_out_b), 64'd5);
      dbg_sel_b = 3'd2; #1; check("b_r2", 64'(dbg_data_b), 64'd5);
      dbg_sel_b = 3'd3; #1; check("b_r3", 64'(dbg_data_b), 64'd3);
      dbg_sel_b = 3'd4; #1; check("b_r4", 64'(dbg_data_b), 64'd8);
      dbg_sel_b = 3'd5; #1; check("b_r5", 64'(dbg_data_b), 64'd4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
